sram_request_arbiter: RTL and testbench
=======================================

# sram_request_arbiter

Upstream front-end for `SRAMController`. It merges two clients into the controller's single-access handshake: a buffered pixel-write stream (camera/processing side) and a single-outstanding read port (display/processing side). Arbitration between them is round-robin. The block issues `read_en`/`wr_en` with a held address and tracks the controller's busy/valid flags. It returns read data to the requester and flags controller hangs with a watchdog.

## Interface
- `ADDR_W`, 18, address width; matches the controller's `address_inputs`.
- `DATA_W`, 16, data width; matches the controller's `dq`.
- `WFIFO_DEPTH`, 4, write FIFO entries; must be a power of two, ≥2.
- `TIMEOUT`, 32, max cycles per controller phase before abort.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: FIFO can accept.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in DATA_W: write data.
- `rd_req` in 1: read request.
- `rd_ready` out 1: read slot free.
- `rd_addr` in ADDR_W: read address.
- `rd_data` out DATA_W: returned read data.
- `rd_data_valid` out 1: one-cycle pulse, `rd_data` valid.
- `mem_read_en` out 1: to controller `read_en`.
- `mem_wr_en` out 1: to controller `wr_en`.
- `mem_addr` out ADDR_W: to controller `address_inputs`.
- `mem_wdata` out DATA_W: write data presented to the controller's data path.
- `mem_rdata` in DATA_W: read data from the controller data path.
- `mem_read_valid` in 1: controller `read_valid`.
- `mem_read_busy` in 1: controller `read_busy`.
- `mem_wr_busy` in 1: controller `wr_busy`.
- `timeout_err` out 1: sticky watchdog flag, cleared only by `rst`.

## Operation
- Write path:
  - A write is accepted when `wr_valid && wr_ready`; `{addr,data}` is pushed into the FIFO.
  - `wr_ready = !full && !rst`.
- Read path:
  - A read is accepted when `rd_req && rd_ready`; the address is latched into `rd_pend_addr` and `rd_pend` is set.
  - `rd_ready = !rd_pend && !rst`.
  - `rd_pend` clears when that read's `rd_data_valid` pulses.
- Arbitration happens only in IDLE:
  - Only one source pending: grant it.
  - Both pending: grant the source not granted last (`last_grant`).
  - `last_grant` resets to WRITE, so the first contention goes to the read.
- FSM states: IDLE, ISSUE_RD, WAIT_RD, DRAIN_RD, ISSUE_WR, WAIT_WR.
  - IDLE → ISSUE_RD / ISSUE_WR on grant. On this transition the block registers `mem_addr`, registers `mem_wdata` (for writes) and sets the enable. For writes, the FIFO pops on this transition.
  - ISSUE_RD: hold `mem_read_en=1` and `mem_addr` until `mem_read_busy=1`, then drop the enable and go to WAIT_RD.
  - WAIT_RD: on the first cycle `mem_read_valid=1`, capture `mem_rdata` into `rd_data`, pulse `rd_data_valid` next cycle, and go to DRAIN_RD. Further cycles of `read_valid` high are ignored.
  - DRAIN_RD: wait for `mem_read_busy=0`, then go to IDLE.
  - ISSUE_WR: hold `mem_wr_en=1` until `mem_wr_busy=1`, then go to WAIT_WR.
  - WAIT_WR: wait for `mem_wr_busy=0`, then go to IDLE.
- `mem_addr` and `mem_wdata` hold their values from issue until the next grant.
- Watchdog:
  - The counter resets on every state entry and counts in all non-IDLE states.
  - When it reaches `TIMEOUT`:
    - set `timeout_err`;
    - drop the enables;
    - go to IDLE.
  - A read abort also pulses `rd_data_valid` with `rd_data=0`, so the requester never hangs.
- Reset (asserted at any point, including mid-access):
  - FSM goes to IDLE and the FIFO empties;
  - `rd_pend` is dropped;
  - all registered outputs return to 0.
  - Controller flags arriving after reset are ignored until a new grant.

## Timing
- Reset values:
  - `mem_read_en`, `mem_wr_en`, `mem_addr`, `mem_wdata`, `rd_data`, `rd_data_valid`, `timeout_err` are all 0.
  - `wr_ready` and `rd_ready` are 0 while `rst` is high and 1 in the first cycle after it.
- Read latency, block idle:
  - Read accepted at edge k: `mem_read_en` is high after edge k+1.
  - `rd_data_valid` is high in the cycle after `mem_read_valid` is first sampled high.
- Write latency, FIFO empty and block idle: a write accepted at edge k drives `mem_wr_en` high after edge k+1.
- All outputs are registered except `wr_ready` and `rd_ready`.
- Simultaneous push and pop on a full FIFO: the pop happens and the push is refused, because `wr_ready=0`.
- FIFO pointers are `$clog2(WFIFO_DEPTH)+1` bits wide and wrap naturally.

## Structure
- Package `sram_arb_pkg`: `ADDR_W`/`DATA_W` defaults, `arb_state_t` enum, `grant_t` {READ, WRITE}.
- Sub-module `sram_wr_fifo`: synchronous FIFO of `{addr,data}` with push/pop/full/empty. The arbiter FSM lives in the top module.

## Test plan
- Single read at `rd_addr=18'h3FFFF`; the controller model raises busy one cycle after the enable and raises `read_valid` 13 cycles later with `mem_rdata=16'hAB04`, `read_valid` held for 2 cycles. Required: `mem_addr=18'h3FFFF`, `mem_read_en` high until busy is seen, and exactly one `rd_data_valid` pulse with `rd_data=16'hAB04`.
- Write burst: 5 back-to-back writes with the controller busy for 10 cycles each → `wr_ready` drops after the 4th is accepted; the controller sees addresses and data in push order.
- Read and write both pending just after reset → the read is issued first, then the write. A second contention grants the write first.
- Watchdog: the controller never raises `read_busy` → at cycle 32 of ISSUE_RD: `timeout_err=1`, `mem_read_en=0`, `rd_data_valid` pulse with `rd_data=0`, FSM back in IDLE.
- Reset mid-read: `rst` is pulsed while in WAIT_RD → on the next cycle all outputs are 0; a later `mem_read_valid` from the model produces no `rd_data_valid`.
- FIFO wrap: 10 writes with random gaps through the depth-4 FIFO → the sequence of issued `{addr,data}` matches the input sequence exactly.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM request arbiter: default widths, FSM states and grant owner.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_RD,
    WAIT_RD,
    DRAIN_RD,
    ISSUE_WR,
    WAIT_WR
  } arb_state_t;

  typedef enum logic {
    READ,
    WRITE
  } grant_t;

endpackage

// File: rtl/sram_request_arbiter_if.sv
// Single-access handshake toward SRAMController; master = arbiter, slave = controller.
interface sram_request_arbiter_if #(
  parameter int ADDR_W = sram_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = sram_arb_pkg::DEF_DATA_W
);

  logic              mem_read_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_read_valid;
  logic              mem_read_busy;
  logic              mem_wr_busy;

  modport master (
    output mem_read_en, mem_wr_en, mem_addr, mem_wdata,
    input  mem_rdata, mem_read_valid, mem_read_busy, mem_wr_busy
  );

  modport slave (
    input  mem_read_en, mem_wr_en, mem_addr, mem_wdata,
    output mem_rdata, mem_read_valid, mem_read_busy, mem_wr_busy
  );

endinterface

// File: rtl/sram_wr_fifo.sv
// Synchronous FIFO for buffered {addr,data} writes; pointers carry one extra wrap bit.
module sram_wr_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] store [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = store[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + PTR_ONE;
      if (pop && !empty) rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) store[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sram_request_arbiter.sv
// Round-robin front-end merging a buffered write stream and a single-outstanding read
// onto SRAMController's read_en/wr_en handshake, with a per-phase watchdog.
module sram_request_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WFIFO_DEPTH = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_req,
  output logic                  rd_ready,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_data_valid,
  output logic                  timeout_err,
  sram_request_arbiter_if.master ctrl
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  arb_state_t        state, state_next;
  grant_t            last_grant;
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_pend_addr;
  logic [WD_W-1:0]   wd_cnt;
  logic              wd_expired, abort;
  logic              grant_rd, grant_wr, rd_capture, rd_abort;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W+DATA_W-1:0] fifo_head;

  logic              read_en_q, wr_en_q;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] rd_data_n;
  logic              read_en_n, wr_en_n, rdv_n, terr_n;

  assign wr_ready = !fifo_full && !rst;
  assign rd_ready = !rd_pend && !rst;

  sram_wr_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(WFIFO_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid && wr_ready),
    .push_data ({wr_addr, wr_data}),
    .pop       (grant_wr),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Under contention the source not served last wins.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state == IDLE) begin
      if (rd_pend && !fifo_empty) begin
        grant_rd = (last_grant == WRITE);
        grant_wr = (last_grant == READ);
      end else begin
        grant_rd = rd_pend;
        grant_wr = !fifo_empty;
      end
    end
  end

  assign wd_expired = (state != IDLE) && (wd_cnt == WD_LAST);
  assign rd_capture = (state == WAIT_RD) && ctrl.mem_read_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Normal progress beats expiry; the watchdog only fires on a stalled phase.
  always_comb begin
    state_next = state;
    abort      = 1'b0;
    unique case (state)
      IDLE:     if (grant_rd) state_next = ISSUE_RD;
                else if (grant_wr) state_next = ISSUE_WR;
      ISSUE_RD: if (ctrl.mem_read_busy) state_next = WAIT_RD;
      WAIT_RD:  if (ctrl.mem_read_valid) state_next = DRAIN_RD;
      DRAIN_RD: if (!ctrl.mem_read_busy) state_next = IDLE;
      ISSUE_WR: if (ctrl.mem_wr_busy) state_next = WAIT_WR;
      WAIT_WR:  if (!ctrl.mem_wr_busy) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (wd_expired && state_next == state) begin
      state_next = IDLE;
      abort      = 1'b1;
    end
  end

  assign rd_abort = abort && (state inside {ISSUE_RD, WAIT_RD});

  always_comb begin
    read_en_n = (state_next == ISSUE_RD);
    wr_en_n   = (state_next == ISSUE_WR);
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    if (grant_rd)      addr_n = rd_pend_addr;
    else if (grant_wr) {addr_n, wdata_n} = fifo_head;
    rdv_n     = rd_capture || rd_abort;
    rd_data_n = rd_data;
    if (rd_capture)    rd_data_n = ctrl.mem_rdata;
    else if (rd_abort) rd_data_n = '0;
    terr_n    = timeout_err || abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_en_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      timeout_err   <= 1'b0;
      rd_pend       <= 1'b0;
      rd_pend_addr  <= '0;
      last_grant    <= WRITE;
      wd_cnt        <= '0;
    end else begin
      read_en_q     <= read_en_n;
      wr_en_q       <= wr_en_n;
      addr_q        <= addr_n;
      wdata_q       <= wdata_n;
      rd_data       <= rd_data_n;
      rd_data_valid <= rdv_n;
      timeout_err   <= terr_n;
      if (rdv_n) rd_pend <= 1'b0;
      if (rd_req && rd_ready) begin
        rd_pend      <= 1'b1;
        rd_pend_addr <= rd_addr;
      end
      if (grant_rd)      last_grant <= READ;
      else if (grant_wr) last_grant <= WRITE;
      if (state != state_next) wd_cnt <= '0;
      else if (state != IDLE)  wd_cnt <= wd_cnt + WD_ONE;
    end
  end

  assign ctrl.mem_read_en = read_en_q;
  assign ctrl.mem_wr_en   = wr_en_q;
  assign ctrl.mem_addr    = addr_q;
  assign ctrl.mem_wdata   = wdata_q;

endmodule

// File: tb/tb_sram_request_arbiter.sv
// Directed bench for sram_request_arbiter with a behavioural SRAMController model.
module tb_sram_request_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [17:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic        rd_ready;
  logic [17:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  sram_request_arbiter_if #(.ADDR_W(18), .DATA_W(16)) ctrl ();

  sram_request_arbiter #(
    .ADDR_W(18), .DATA_W(16), .WFIFO_DEPTH(4), .TIMEOUT(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_req        (rd_req),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .timeout_err   (timeout_err),
    .ctrl          (ctrl)
  );

  always #5 clk = ~clk;

  // Controller model: busy one cycle after the enable is seen; a read returns
  // read_valid 13 cycles after busy for 2 cycles; a write stays busy 10 cycles.
  bit          model_on = 1'b1;
  logic [15:0] model_rdata = 16'hAB04;
  int          mcnt = 0;
  bit          mact = 1'b0;
  bit          mwr = 1'b0;
  logic [33:0] wlog[$];

  always @(negedge clk) begin
    if (!model_on) begin
      mact = 1'b0;
    end else if (!mact && (ctrl.mem_read_en || ctrl.mem_wr_en)) begin
      mact = 1'b1;
      mwr  = ctrl.mem_wr_en;
      mcnt = 0;
      if (ctrl.mem_wr_en) wlog.push_back({ctrl.mem_addr, ctrl.mem_wdata});
    end else if (mact) begin
      mcnt++;
    end
    ctrl.mem_read_busy  = mact && !mwr && mcnt >= 1 && mcnt < 17;
    ctrl.mem_read_valid = mact && !mwr && mcnt >= 14 && mcnt < 16;
    ctrl.mem_rdata      = ctrl.mem_read_valid ? model_rdata : 16'h0;
    ctrl.mem_wr_busy    = mact && mwr && mcnt >= 1 && mcnt < 11;
    if (mact && mcnt >= (mwr ? 11 : 17)) mact = 1'b0;
  end

  int          rdv_cnt = 0;
  logic [15:0] rdv_last = '0;
  always @(negedge clk) begin
    if (rd_data_valid) begin
      rdv_cnt++;
      rdv_last = rd_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_wr(input logic [17:0] a, input logic [15:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && n < 300) begin
      tick(1);
      n++;
    end
    check("wr_accept", {63'b0, wr_ready}, 64'd1);
    tick(1);
    wr_valid = 1'b0;
  endtask

  task automatic wait_en(input bit wr, output bit seen);
    int n = 0;
    while (!(wr ? ctrl.mem_wr_en : ctrl.mem_read_en) && n < 200) begin
      tick(1);
      n++;
    end
    seen = wr ? ctrl.mem_wr_en : ctrl.mem_read_en;
  endtask

  function automatic logic [63:0] all_outs();
    return {8'b0, ctrl.mem_read_en, ctrl.mem_wr_en, ctrl.mem_addr, ctrl.mem_wdata,
            rd_data, rd_data_valid, timeout_err, wr_ready, rd_ready};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [33:0] exp_q[$];
    logic [33:0] e;
    bit seen;
    int base;
    int n;

    // Reset state
    tick(3);
    check("reset_outs", all_outs(), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", {62'b0, wr_ready, rd_ready}, 64'd3);

    // Single read at the top address
    base = rdv_cnt;
    rd_req = 1'b1; rd_addr = 18'h3FFFF;
    tick(1);
    rd_req = 1'b0;
    check("rd_ready_low", {63'b0, rd_ready}, 64'd0);
    check("rd_not_yet", {63'b0, ctrl.mem_read_en}, 64'd0);
    tick(1);
    check("rd_issue", {45'b0, ctrl.mem_read_en, ctrl.mem_addr}, {45'b0, 1'b1, 18'h3FFFF});
    tick(1);
    check("rd_en_hold", {63'b0, ctrl.mem_read_en}, 64'd1);
    tick(1);
    check("rd_en_drop", {63'b0, ctrl.mem_read_en}, 64'd0);
    tick(12);
    check("rdv_early", {63'b0, rd_data_valid}, 64'd0);
    tick(1);
    check("rdv_pulse", {47'b0, rd_data_valid, rd_data}, {47'b0, 1'b1, 16'hAB04});
    tick(1);
    check("rdv_single", {63'b0, rd_data_valid}, 64'd0);
    tick(5);
    check("rd_one_pulse", 64'(rdv_cnt - base), 64'd1);
    check("rd_addr_held", {46'b0, ctrl.mem_addr}, {46'b0, 18'h3FFFF});

    // Write burst behind a read; FIFO fills with 4, 5th waits
    wlog.delete();
    model_rdata = 16'h1234;
    rd_req = 1'b1; rd_addr = 18'h00100;
    tick(1);
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) send_wr(18'h00200 + 18'(i), 16'hA000 + 16'(i));
    check("fifo_full", {63'b0, wr_ready}, 64'd0);
    send_wr(18'h00204, 16'hA004);
    n = 0;
    while (wlog.size() < 5 && n < 400) begin
      tick(1);
      n++;
    end
    tick(15);
    check("burst_count", 64'(wlog.size()), 64'd5);
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      check("burst_order", 64'(wlog[i]), 64'({18'h00200 + 18'(i), 16'hA000 + 16'(i)}));
    check("burst_rd_data", {48'b0, rdv_last}, {48'b0, 16'h1234});

    // Contention right after reset: read first, then write; then write wins
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
    rd_req = 1'b1; rd_addr = 18'h00AAA;
    wr_valid = 1'b1; wr_addr = 18'h00BBB; wr_data = 16'h5555;
    tick(1);
    rd_req = 1'b0; wr_valid = 1'b0;
    tick(1);
    check("cont1_rd_first", {44'b0, ctrl.mem_read_en, ctrl.mem_wr_en, ctrl.mem_addr},
          {44'b0, 2'b10, 18'h00AAA});
    n = 0;
    while (!rd_ready && n < 200) begin
      tick(1);
      n++;
    end
    check("cont1_rd_done", {63'b0, rd_ready}, 64'd1);
    rd_req = 1'b1; rd_addr = 18'h00CCC;
    tick(1);
    rd_req = 1'b0;
    wait_en(1'b1, seen);
    check("cont2_wr_seen", {63'b0, seen}, 64'd1);
    check("cont2_wr_first", {29'b0, ctrl.mem_read_en, ctrl.mem_addr, ctrl.mem_wdata},
          {29'b0, 1'b0, 18'h00BBB, 16'h5555});
    wait_en(1'b0, seen);
    check("cont2_rd_seen", {63'b0, seen}, 64'd1);
    check("cont2_rd_addr", {46'b0, ctrl.mem_addr}, {46'b0, 18'h00CCC});
    tick(20);

    // Watchdog: controller never answers
    model_on = 1'b0;
    tick(1);
    rd_req = 1'b1; rd_addr = 18'h12345;
    tick(1);
    rd_req = 1'b0;
    tick(1);
    check("wd_issue", {63'b0, ctrl.mem_read_en}, 64'd1);
    tick(31);
    check("wd_before", {62'b0, ctrl.mem_read_en, timeout_err}, 64'd2);
    tick(1);
    check("wd_abort", {45'b0, timeout_err, ctrl.mem_read_en, rd_data_valid, rd_data, rd_ready},
          {45'b0, 3'b101, 16'h0, 1'b1});
    model_on = 1'b1;
    tick(1);
    check("wd_pulse_end", {63'b0, rd_data_valid}, 64'd0);
    send_wr(18'h0F0F0, 16'hBEEF);
    check("wd_wr_latency", {63'b0, ctrl.mem_wr_en}, 64'd0);
    tick(1);
    check("wd_idle_wr", {29'b0, ctrl.mem_wr_en, ctrl.mem_addr, ctrl.mem_wdata},
          {29'b0, 1'b1, 18'h0F0F0, 16'hBEEF});
    check("terr_sticky", {63'b0, timeout_err}, 64'd1);
    tick(15);

    // Reset mid-read
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    check("terr_cleared", {63'b0, timeout_err}, 64'd0);
    model_rdata = 16'h7777;
    rd_req = 1'b1; rd_addr = 18'h22222;
    tick(1);
    rd_req = 1'b0;
    tick(1);
    check("rst_rd_issue", {45'b0, ctrl.mem_read_en, ctrl.mem_addr}, {45'b0, 1'b1, 18'h22222});
    tick(3);
    rst = 1'b1;
    tick(1);
    check("rst_mid_outs", all_outs(), 64'd0);
    rst = 1'b0;
    #1;
    base = rdv_cnt;
    tick(16);
    check("rst_no_pulse", 64'(rdv_cnt - base), 64'd0);
    check("rst_quiet", all_outs(), {62'b0, 2'b11});

    // FIFO wrap with random gaps
    wlog.delete();
    for (int i = 0; i < 10; i++) begin
      int g;
      e = {18'h01000 + 18'(i * 37), 16'($urandom)};
      exp_q.push_back(e);
      send_wr(e[33:16], e[15:0]);
      g = $urandom_range(0, 3);
      if (g > 0) tick(g);
    end
    n = 0;
    while (wlog.size() < 10 && n < 800) begin
      tick(1);
      n++;
    end
    tick(15);
    check("wrap_count", 64'(wlog.size()), 64'd10);
    for (int i = 0; i < 10 && i < wlog.size(); i++)
      check("wrap_order", 64'(wlog[i]), 64'(exp_q[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
